// File: rtl/cpu_pkg.sv
// Shared types and helpers for the MIPS pipeline front end.
package cpu_pkg;

  typedef logic [31:0] pc_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Widen a 16-bit two's-complement value to 32 bits.
  function automatic logic signed [31:0] sign_extend16to32(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next fetch address selection: jr > jump > taken branch > stall > sequential.
// A redirect only counts when the instruction in IF/ID that produced it is valid.
module next_pc_sel
  import cpu_pkg::*;
(
  input  pc_t                pc,
  input  pc_t                id_pc_plus1,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic signed [15:0] branch_imm,
  input  logic               jump,
  input  logic [25:0]        jump_addr,
  input  logic               jr,
  input  pc_t                jr_target,
  output pc_t                next_pc,
  output logic               redirect
);

  logic signed [31:0] br_off;
  pc_t                br_target;
  pc_t                jump_target;

  assign br_off      = sign_extend16to32(branch_imm);
  assign br_target   = pc_t'($signed(id_pc_plus1) + br_off);
  assign jump_target = {id_pc_plus1[31:26], jump_addr};

  // Priority mux over the redirect sources, then stall, then pc+1.
  always_comb begin
    redirect = id_valid & (jr | jump | branch_taken);
    next_pc  = pc + 32'd1;
    if (redirect) begin
      if (jr)        next_pc = jr_target;
      else if (jump) next_pc = jump_target;
      else           next_pc = br_target;
    end else if (stall) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, RUN/HALTED control
// and a count of valid instructions delivered to decode.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
)(
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus1,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_nx;

  pc_t         pc_p0;
  pc_t         next_pc;
  logic        redirect;
  logic        advance;
  logic        squash;
  logic        halt_now;

  logic [31:0] instr_p1;
  pc_t         pc_p1;
  pc_t         pc_plus1_p1;
  logic        vld_p1;
  logic [31:0] count_q;

  next_pc_sel u_next_pc_sel (
    .pc           (pc_p0),
    .id_pc_plus1  (pc_plus1_p1),
    .id_valid     (vld_p1),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .jr           (jr),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .redirect     (redirect)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // Next state and per-edge action: halt beats redirect, redirect beats stall.
  always_comb begin
    state_nx = state;
    halt_now = 1'b0;
    advance  = 1'b0;
    squash   = 1'b0;
    case (state)
      RUN: begin
        if (halt) begin
          state_nx = HALTED;
          halt_now = 1'b1;
        end else if (redirect) begin
          squash = 1'b1;
        end else if (!stall) begin
          advance = 1'b1;
        end
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  // p0: program counter, moves on a normal advance or a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 pc_p0 <= RESET_PC;
    else if (advance || squash) pc_p0 <= next_pc;
  end

  // p1: IF/ID register; a squash or halt leaves a bubble with the data untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1    <= NOP_INSTR;
      pc_p1       <= '0;
      pc_plus1_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (advance) begin
      instr_p1    <= instr_in;
      pc_p1       <= pc_p0;
      pc_plus1_p1 <= pc_p0 + 32'd1;
      vld_p1      <= 1'b1;
    end else if (squash || halt_now) begin
      vld_p1      <= 1'b0;
    end
  end

  // Count every instruction that enters IF/ID as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count_q <= '0;
    else if (advance) count_q <= count_q + 32'd1;
  end

  assign pc          = pc_p0;
  assign id_instr    = instr_p1;
  assign id_pc       = pc_p1;
  assign id_pc_plus1 = pc_plus1_p1;
  assign id_valid    = vld_p1;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized control traffic checked every cycle against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr_in;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_addr = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus1;
  logic        id_valid;
  logic [31:0] fetch_count;

  logic [31:0] mem [256];
  int checks = 0;
  int errors = 0;

  // Behavioural model of what decode should see.
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_idpc = 32'h0, m_ppc1 = 32'h0, m_count = 32'h0;
  logic        m_valid = 1'b0, m_halted = 1'b0;

  localparam logic [31:0] WA = 32'hA000_000A, WB = 32'hB000_000B;
  localparam logic [31:0] WC = 32'hC000_000C, WD = 32'hD000_000D;

  assign instr_in = mem[pc[7:0]];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .instr_in     (instr_in),
    .stall        (stall),
    .halt         (halt),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .jr           (jr),
    .jr_target    (jr_target),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus1  (id_pc_plus1),
    .id_valid     (id_valid),
    .fetch_count  (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
  endtask

  // Model update and compare on every edge, and immediately on reset assertion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_idpc = 32'h0; m_ppc1 = 32'h0;
      m_count = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (halt) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else if (m_valid && (jr || jump || branch_taken)) begin
      if (jr)        m_pc = jr_target;
      else if (jump) m_pc = {m_ppc1[31:26], jump_addr};
      else           m_pc = m_ppc1 + {{16{branch_imm[15]}}, branch_imm};
      m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = mem[m_pc[7:0]];
      m_idpc  = m_pc;
      m_ppc1  = m_pc + 32'd1;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
      m_pc    = m_pc + 32'd1;
    end
    #1;
    chk("model_pc", pc, m_pc);
    chk("model_valid", {31'b0, id_valid}, {31'b0, m_valid});
    chk("model_count", fetch_count, m_count);
    if (m_valid) begin
      chk("model_instr", id_instr, m_instr);
      chk("model_id_pc", id_pc, m_idpc);
      chk("model_pc_plus1", id_pc_plus1, m_ppc1);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD;

    // Reset state.
    repeat (3) tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'b0, id_valid}, 32'h0);
    chk("reset_count", fetch_count, 32'h0);
    chk("reset_instr", id_instr, 32'h0);

    // Sequential fetch from RESET_PC.
    rst_n = 1'b1;
    tick(); chk("seq_instr0", id_instr, WA); chk("seq_idpc0", id_pc, 32'd0); chk("seq_v0", {31'b0, id_valid}, 32'd1);
    tick(); chk("seq_instr1", id_instr, WB); chk("seq_idpc1", id_pc, 32'd1);
    tick(); chk("seq_instr2", id_instr, WC); chk("seq_idpc2", id_pc, 32'd2); chk("seq_pc3", pc, 32'd3);

    // Stall for three edges while id_pc = 2.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc, 32'd3);
      chk("stall_idpc", id_pc, 32'd2);
      chk("stall_instr", id_instr, WC);
      chk("stall_count", fetch_count, 32'd3);
    end
    stall = 1'b0;
    tick(); chk("resume_instr", id_instr, WD); chk("resume_idpc", id_pc, 32'd3); chk("count4", fetch_count, 32'd4);

    // Backward branch from id_pc = 5.
    tick(); tick();
    chk("pre_br_idpc", id_pc, 32'd5);
    branch_taken = 1'b1; branch_imm = 16'hFFFE;
    tick(); chk("br_pc", pc, 32'd4); chk("br_bubble", {31'b0, id_valid}, 32'd0);
    clear_ctl();
    tick(); chk("br_idpc", id_pc, 32'd4); chk("br_valid", {31'b0, id_valid}, 32'd1);
    chk("br_instr", id_instr, mem[4]); chk("br_count", fetch_count, 32'd7);

    // All redirects plus stall together: jr wins.
    jr = 1'b1; jump = 1'b1; branch_taken = 1'b1; stall = 1'b1;
    jr_target = 32'h40; jump_addr = 26'h123; branch_imm = 16'h0010;
    tick(); chk("multi_pc", pc, 32'h40); chk("multi_bubble", {31'b0, id_valid}, 32'd0);
    clear_ctl();
    tick(); chk("multi_idpc", id_pc, 32'h40); chk("multi_count", fetch_count, 32'd8);

    // Jump alone while id_pc = 0x40.
    jump = 1'b1; jump_addr = 26'h3F;
    tick(); chk("jump_pc", pc, 32'h3F); chk("jump_bubble", {31'b0, id_valid}, 32'd0);
    clear_ctl();
    tick(); chk("jump_idpc", id_pc, 32'h3F); chk("jump_count", fetch_count, 32'd9);

    // PC wrap at 2^32.
    jr = 1'b1; jr_target = 32'hFFFF_FFFF;
    tick(); chk("wrap_pre_pc", pc, 32'hFFFF_FFFF);
    clear_ctl();
    tick(); chk("wrap_pc", pc, 32'h0); chk("wrap_idpc", id_pc, 32'hFFFF_FFFF);
    chk("wrap_ppc1", id_pc_plus1, 32'h0); chk("wrap_instr", id_instr, mem[255]);
    tick(); chk("post_wrap_pc", pc, 32'd1); chk("post_wrap_count", fetch_count, 32'd11);

    // Halt, then redirects and stalls must have no effect.
    halt = 1'b1;
    tick(); chk("halt_pc", pc, 32'd1); chk("halt_valid", {31'b0, id_valid}, 32'd0); chk("halt_count", fetch_count, 32'd11);
    halt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      jr = 1'b1; jr_target = $urandom; branch_taken = 1'($urandom); stall = 1'($urandom);
      tick();
      chk("halted_pc", pc, 32'd1);
      chk("halted_valid", {31'b0, id_valid}, 32'd0);
      chk("halted_count", fetch_count, 32'd11);
    end
    clear_ctl();

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'b0, id_valid}, 32'd0);
    chk("async_count", fetch_count, 32'd0);
    chk("async_instr", id_instr, 32'd0);
    chk("async_ppc1", id_pc_plus1, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Randomized control traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 19) == 0);
      jr           = ($urandom_range(0, 19) == 0);
      branch_imm   = 16'($urandom);
      jump_addr    = 26'($urandom);
      jr_target    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1)) : $urandom;
      halt         = (i == 2980);
      tick();
    end
    clear_ctl();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
